// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One binary operand is accepted per START. The result appears BIN_WIDTH
// clocks later together with a one-cycle DONE pulse. BCD keeps the previous
// result until the completion edge, so the 7-segment driver never sees a
// partially converted value.

// Single-digit add-3 correction. Codes 10..15 cannot occur while the
// DIGITS/BIN_WIDTH relation holds; they map to 0.
module bin_to_bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  // Pass 0..4 unchanged, add 3 to 5..9, clear out-of-range codes
  always_comb begin
    corrected = 4'd0;
    case (digit)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: corrected = digit;
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9: corrected = digit + 4'd3;
      default:                      corrected = 4'd0;
    endcase
  end

endmodule

module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [BIN_WIDTH-1:0]  BIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   BCD
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_nxt_s;
  logic [BIN_WIDTH-1:0] shift_r;
  logic [BIN_WIDTH-1:0] shift_nxt_s;
  logic [SW-1:0]        scratch_r;
  logic [SW-1:0]        scratch_nxt_s;
  logic [SW-1:0]        bcd_r;
  logic [SW-1:0]        bcd_nxt_s;
  logic                 busy_r;
  logic                 busy_nxt_s;
  logic                 done_r;
  logic                 done_nxt_s;

  logic [SW-1:0]        corrected_s;
  logic [SW-1:0]        scratch_shifted_s;
  logic [BIN_WIDTH-1:0] shift_shifted_s;
  logic                 last_step_s;

  // One add-3 corrector per BCD digit of the scratch register
  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bin_to_bcd_add3 u_add3 (
      .digit     (scratch_r[4*k +: 4]),
      .corrected (corrected_s[4*k +: 4])
    );
  end

  // The top scratch bit falls off; the shift-register MSB enters the units digit
  assign scratch_shifted_s = {corrected_s[SW-2:0], shift_r[BIN_WIDTH-1]};
  assign shift_shifted_s   = {shift_r[BIN_WIDTH-2:0], 1'b0};
  assign last_step_s       = (cnt_r == CW'(1));

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      shift_r   <= {BIN_WIDTH{1'b0}};
      scratch_r <= {SW{1'b0}};
      bcd_r     <= {SW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      shift_r   <= shift_nxt_s;
      scratch_r <= scratch_nxt_s;
      bcd_r     <= bcd_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

  // Next-state decode: IDLE waits for START, SHIFT runs until the last step
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_step_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath and output next values; BCD loads only on the completion edge
  always_comb begin
    cnt_nxt_s     = cnt_r;
    shift_nxt_s   = shift_r;
    scratch_nxt_s = scratch_r;
    bcd_nxt_s     = bcd_r;
    busy_nxt_s    = 1'b0;
    done_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          shift_nxt_s   = BIN;
          scratch_nxt_s = {SW{1'b0}};
          cnt_nxt_s     = CW'(BIN_WIDTH);
          busy_nxt_s    = 1'b1;
        end else begin
          busy_nxt_s    = 1'b0;
        end
      end
      ST_SHIFT: begin
        scratch_nxt_s = scratch_shifted_s;
        shift_nxt_s   = shift_shifted_s;
        cnt_nxt_s     = cnt_r - CW'(1);
        if (last_step_s) begin
          bcd_nxt_s  = scratch_shifted_s;
          done_nxt_s = 1'b1;
          busy_nxt_s = 1'b0;
        end else begin
          busy_nxt_s = 1'b1;
        end
      end
      default: begin
        cnt_nxt_s     = {CW{1'b0}};
        shift_nxt_s   = {BIN_WIDTH{1'b0}};
        scratch_nxt_s = {SW{1'b0}};
        bcd_nxt_s     = {SW{1'b0}};
      end
    endcase
  end

  assign BUSY = busy_r;
  assign DONE = done_r;
  assign BCD  = bcd_r;

endmodule
